// File: rtl/sum8_iob_master_pkg.sv
// Shared constants, FSM state encoding and accumulator sizing for sum8_iob_master.
// The package is the same whether or not SUM8_WRITEBACK_EN is defined.
package sum8_iob_master_pkg;

    localparam int FE_ADDR_W = 22;
    localparam int FE_DATA_W = 32;
    localparam int FE_STRB_W = FE_DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    // One extra bit is kept even for N=1 so the overflow slice is never empty.
    function automatic int acc_width(input int data_w, input int n_words);
        return data_w + ((n_words > 1) ? $clog2(n_words) : 1);
    endfunction

endpackage

// File: rtl/sum8_accum.sv
// Registered unsigned accumulator with synchronous clear and enable.
// Exposes the low word of the current sum and of the pending add, plus overflow.
module sum8_accum
    import sum8_iob_master_pkg::*;
#(
    parameter int DATA_W = FE_DATA_W,
    parameter int ACC_W  = acc_width(FE_DATA_W, 8)
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] add_i,
    output logic [DATA_W-1:0] result_o,
    output logic [DATA_W-1:0] sum_lo_o,
    output logic              overflow_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum;

    assign sum = acc_q + ACC_W'(add_i);

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign result_o   = acc_q[DATA_W-1:0];
    assign sum_lo_o   = sum[DATA_W-1:0];
    assign overflow_o = |acc_q[ACC_W-1:DATA_W];

endmodule

// File: rtl/sum8_iob_master.sv
// IOb master that sums N_WORDS consecutive words starting at base_addr_i.
// Define SUM8_WRITEBACK_EN to write the 32-bit sum to dst_addr_i before done_o.
module sum8_iob_master
    import sum8_iob_master_pkg::*;
#(
    parameter int N_WORDS = 8,
    parameter int ADDR_W  = FE_ADDR_W,
    parameter int DATA_W  = FE_DATA_W,
    parameter int STRB_W  = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              overflow_o,
    output logic              iob_valid_o,
    output logic [ADDR_W-1:0] iob_addr_o,
    output logic [DATA_W-1:0] iob_wdata_o,
    output logic [STRB_W-1:0] iob_wstrb_o,
    input  logic [DATA_W-1:0] iob_rdata_i,
    input  logic              iob_rvalid_i,
    input  logic              iob_ready_i
);

    localparam int ACC_W = acc_width(DATA_W, N_WORDS);
    localparam int IDX_W = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              acc_clr;
    logic              acc_en;
    logic [DATA_W-1:0] wb_sum;

`ifdef SUM8_WRITEBACK_EN
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_sum, dst_addr_i};
`endif

    sum8_accum #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_accum (
        .clk_i      (clk_i),
        .arst_n_i   (arst_n_i),
        .clr_i      (acc_clr),
        .en_i       (acc_en),
        .add_i      (iob_rdata_i),
        .result_o   (result_o),
        .sum_lo_o   (wb_sum),
        .overflow_o (overflow_o)
    );

    // Bus outputs are computed from the next state so they leave as registers.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        addr_d  = addr_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
`ifdef SUM8_WRITEBACK_EN
        dst_d   = dst_q;
        wdata_d = wdata_q;
        wstrb_d = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RD_REQ;
                    base_d  = base_addr_i;
                    addr_d  = base_addr_i;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    acc_clr = 1'b1;
`ifdef SUM8_WRITEBACK_EN
                    dst_d   = dst_addr_i;
`endif
                end
            end
            S_RD_REQ: begin
                valid_d = 1'b1;
                if (iob_ready_i) begin
                    valid_d = 1'b0;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (iob_rvalid_i) begin
                    acc_en = 1'b1;
                    if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + IDX_W'(1);
                        addr_d  = base_q + ADDR_W'({idx_d, 2'b00});
                        valid_d = 1'b1;
                        state_d = S_RD_REQ;
                    end else begin
`ifdef SUM8_WRITEBACK_EN
                        state_d = S_WR_REQ;
                        addr_d  = dst_q;
                        wdata_d = wb_sum;
                        wstrb_d = '1;
                        valid_d = 1'b1;
`else
                        state_d = S_DONE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef SUM8_WRITEBACK_EN
            S_WR_REQ: begin
                valid_d = 1'b1;
                wstrb_d = '1;
                if (iob_ready_i) begin
                    valid_d = 1'b0;
                    wstrb_d = '0;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef SUM8_WRITEBACK_EN
            dst_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
`ifdef SUM8_WRITEBACK_EN
            dst_q   <= dst_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
`endif
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign iob_valid_o = valid_q;
    assign iob_addr_o  = addr_q;
`ifdef SUM8_WRITEBACK_EN
    assign iob_wdata_o = wdata_q;
    assign iob_wstrb_o = wstrb_q;
`else
    assign iob_wdata_o = '0;
    assign iob_wstrb_o = '0;
`endif

endmodule
